// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared CPU definitions for the multiply/divide unit and the
// decoder that drives it.
//   md_op_t / md_op_e : 4-bit operation code carried on the md_op bus
//   md_state_e        : md_unit sequencer states
//   MULT_CYCLES       : busy cycles for MULT/MULTU
//   DIV_CYCLES        : busy cycles for DIV/DIVU
package md_unit_pkg;

  typedef logic [3:0] md_op_t;

  // Codes 9..15 are unused and decode as OP_NONE.
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_long_op(md_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // MULT and DIV treat their operands as two's complement.
  function automatic logic is_signed_op(md_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: issue/result bundle between the decode/execute stage and
// md_unit.
//   start   : issue strobe, qualified by md_op
//   md_op   : operation code (md_unit_pkg::md_op_e encoding)
//   rs_data : first operand (register-file read port 1)
//   rt_data : second operand (register-file read port 2)
//   busy    : a MULT/MULTU/DIV/DIVU is in flight
//   hi, lo  : committed HI/LO registers
//   mf_data : MFHI/MFLO read data toward the register-file write path
// Modports: master = decode/execute side, slave = md_unit side.
interface md_unit_if;
  import md_unit_pkg::*;

  logic        start;
  md_op_t      md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  modport master (
    output start, md_op, rs_data, rt_data,
    input  busy, hi, lo, mf_data
  );

  modport slave (
    input  start, md_op, rs_data, rt_data,
    output busy, hi, lo, mf_data
  );

endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears HI/LO, counter, latched operands
//   bus   : md_unit_if.slave (start, md_op, rs_data, rt_data in;
//           busy, hi, lo, mf_data out)
// MULT/MULTU take MULT_CYCLES cycles and DIV/DIVU take DIV_CYCLES cycles;
// the result is computed combinationally from the operands latched at issue
// and committed to HI/LO on the last busy edge. MTHI/MTLO write in one edge.
module md_unit
  import md_unit_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  md_op_t      op_q, op_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] a_ext, b_ext, product;
  logic        op_signed, a_neg, b_neg, div_by_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic        busy;
  logic [31:0] mf_data;

  // State register. Reset wins over everything, so an operation whose last
  // edge coincides with reset is dropped without touching HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Result datapath, driven only by the latched operands.
  // Multiply: extend both operands to 64 bits (sign or zero) and keep the
  // low 64 bits of the product, which is exact for both signednesses.
  // Divide: a single unsigned divider on magnitudes, then re-sign. This
  // makes 0x80000000 / -1 fall out naturally as 0x80000000 rem 0.
  always_comb begin
    op_signed   = is_signed_op(op_q);
    a_ext       = op_signed ? {{32{rs_q[31]}}, rs_q} : {32'd0, rs_q};
    b_ext       = op_signed ? {{32{rt_q[31]}}, rt_q} : {32'd0, rt_q};
    product     = a_ext * b_ext;

    a_neg       = op_signed & rs_q[31];
    b_neg       = op_signed & rt_q[31];
    a_mag       = a_neg ? (32'd0 - rs_q) : rs_q;
    b_mag       = b_neg ? (32'd0 - rt_q) : rt_q;
    div_by_zero = (rt_q == 32'd0);
    q_mag       = '0;
    r_mag       = '0;
    if (!div_by_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem  = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_long_op(bus.md_op)) begin
            op_d    = bus.md_op;
            rs_d    = bus.rs_data;
            rt_d    = bus.rt_data;
            cnt_d   = is_div_op(bus.md_op) ? DIV_CYCLES : MULT_CYCLES;
            state_d = ST_RUN;
          end else if (bus.md_op == OP_MTHI) begin
            hi_d = bus.rs_data;
          end else if (bus.md_op == OP_MTLO) begin
            lo_d = bus.rs_data;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          if (is_div_op(op_q)) begin
            // Divide by zero still spends the full latency but commits nothing.
            if (!div_by_zero) begin
              hi_d = rem;
              lo_d = quot;
            end
          end else begin
            hi_d = product[63:32];
            lo_d = product[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. mf_data reads committed HI/LO and ignores start.
  always_comb begin
    busy    = (state_q == ST_RUN);
    mf_data = '0;
    if (bus.md_op == OP_MFHI) begin
      mf_data = hi_q;
    end else if (bus.md_op == OP_MFLO) begin
      mf_data = lo_q;
    end
  end

  assign bus.busy    = busy;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mf_data = mf_data;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit. Each long operation pushes its
// hand-computed HI/LO and busy length into a queue; a monitor pops one entry
// whenever busy falls and compares. Single-cycle ops are checked inline.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic reset;

  md_unit_if bus ();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic prev_busy  = 1'b0;
  int   run_len    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives a one-cycle start pulse; returns #1 after the capturing edge.
  task automatic applyStimulus(input md_op_t op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start   = 1'b1;
    bus.md_op   = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.md_op = OP_NONE;
  endtask

  task automatic expectResult(input string name, input logic [31:0] hi, input logic [31:0] lo,
                              input int cycles);
    exp_t e;
    e.name   = name;
    e.hi     = hi;
    e.lo     = lo;
    e.cycles = cycles;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) until busy is low, then returns #1 after the next edge.
  task automatic waitIdle(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runOp(input string name, input md_op_t op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] hi, input logic [31:0] lo,
                       input int cycles);
    expectResult(name, hi, lo, cycles);
    applyStimulus(op, rs, rt);
    // Operand changes during RUN must not affect the result.
    bus.rs_data = 32'hDEAD_BEEF;
    bus.rt_data = 32'h0000_0000;
    waitIdle(name);
  endtask

  // Monitor: measures each busy run and scores it when busy falls.
  always @(negedge clk) begin
    if (bus.busy === 1'b1) begin
      run_len = run_len + 1;
    end else if (prev_busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_completion: hi=%h lo=%h, expected no result", bus.hi, bus.lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput({e.name, "_hi"}, bus.hi, e.hi);
        checkOutput({e.name, "_lo"}, bus.lo, e.lo);
        checkOutput({e.name, "_busy_len"}, 32'(run_len), 32'(e.cycles));
      end
      run_len = 0;
    end
    prev_busy = bus.busy;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.md_op   = OP_NONE;
    bus.rs_data = '0;
    bus.rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.md_op = OP_MFHI;
    @(negedge clk);
    checkOutput("reset_hi", bus.hi, 32'h0);
    checkOutput("reset_lo", bus.lo, 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    checkOutput("reset_mf", bus.mf_data, 32'h0);
    @(posedge clk);
    #1;
    bus.md_op = OP_NONE;

    // MULT -2 * 3 = -6, with a MULT issued mid-flight that must be ignored.
    expectResult("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    @(posedge clk);
    #1;
    applyStimulus(OP_MULT, 32'h0000_0001, 32'h0000_0001);
    bus.rs_data = 32'h1111_1111;
    waitIdle("mult_neg");

    runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    runOp("divu_by0", OP_DIVU, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    runOp("div_7_m2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    runOp("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 10);

    // MTHI then MFHI on the next cycle.
    applyStimulus(OP_MTHI, 32'h1234_5678, 32'h0);
    bus.start = 1'b1;
    bus.md_op = OP_MFHI;
    @(negedge clk);
    checkOutput("mfhi_data", bus.mf_data, 32'h1234_5678);
    checkOutput("mthi_busy", 32'(bus.busy), 32'h0);
    checkOutput("mthi_lo_kept", bus.lo, 32'h7FFF_FFFC);
    @(posedge clk);
    #1;
    applyStimulus(OP_MTLO, 32'hCAFE_F00D, 32'h0);
    bus.md_op = OP_MFLO;
    @(negedge clk);
    checkOutput("mflo_data", bus.mf_data, 32'hCAFE_F00D);
    checkOutput("mtlo_hi_kept", bus.hi, 32'h1234_5678);
    @(posedge clk);
    #1;

    // Unused op codes with start change nothing; mf_data is 0 for non-MF ops.
    applyStimulus(md_op_t'(4'd9), 32'hAAAA_AAAA, 32'h5555_5555);
    applyStimulus(OP_MFHI, 32'hAAAA_AAAA, 32'h5555_5555);
    bus.md_op = OP_MULT;
    @(negedge clk);
    checkOutput("noop_hi", bus.hi, 32'h1234_5678);
    checkOutput("noop_lo", bus.lo, 32'hCAFE_F00D);
    checkOutput("noop_busy", 32'(bus.busy), 32'h0);
    checkOutput("mf_other_op", bus.mf_data, 32'h0);
    @(posedge clk);
    #1;
    bus.md_op = OP_NONE;

    // DIV cancelled by reset in its 10th busy cycle (the completion edge).
    expectResult("div_reset", 32'h0, 32'h0, 10);
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_run_busy", 32'(bus.busy), 32'h0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_run_hi", bus.hi, 32'h0);
    checkOutput("rst_run_lo", bus.lo, 32'h0);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
